// File: rtl/max_pool2d_relu.sv
// max_pool2d_relu: captures a flattened FP32 feature map, walks every pooling
// window one element per clock, keeps the running maximum, optionally clamps
// negative maxima to +0 and writes them into a flat result bus.
// The start/finish handshake matches the upstream Conv2d block.
module max_pool2d_relu #(
  parameter int BITWIDTH     = 32,
  parameter int DATAWIDTH    = 2,
  parameter int DATAHEIGHT   = 2,
  parameter int DATACHANNEL  = 2,
  parameter int POOLHEIGHT   = 2,
  parameter int POOLWIDTH    = 2,
  parameter int STRIDEHEIGHT = 2,
  parameter int STRIDEWIDTH  = 2,
  parameter int RELUENABLE   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0] data,
  output logic [BITWIDTH*((DATAWIDTH-POOLWIDTH)/STRIDEWIDTH+1)*
                ((DATAHEIGHT-POOLHEIGHT)/STRIDEHEIGHT+1)*DATACHANNEL-1:0] result,
  output logic finish,
  output logic busy
);

  localparam int OH = (DATAHEIGHT - POOLHEIGHT) / STRIDEHEIGHT + 1;
  localparam int OW = (DATAWIDTH - POOLWIDTH) / STRIDEWIDTH + 1;
  localparam int IN_W = BITWIDTH * DATAWIDTH * DATAHEIGHT * DATACHANNEL;
  localparam int CW = 16;

  localparam logic [CW-1:0] PW_LAST = CW'(POOLWIDTH - 1);
  localparam logic [CW-1:0] PH_LAST = CW'(POOLHEIGHT - 1);
  localparam logic [CW-1:0] OW_LAST = CW'(OW - 1);
  localparam logic [CW-1:0] OH_LAST = CW'(OH - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(DATACHANNEL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t state;

  logic [CW-1:0] ch;
  logic [CW-1:0] orow;
  logic [CW-1:0] ocol;
  logic [CW-1:0] wr;
  logic [CW-1:0] wc;

  logic [IN_W-1:0]     in_reg;
  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] elem;
  int                  elem_idx;
  int                  out_idx;
  logic                capture;
  logic                first_elem;

  // Strict FP32 greater-than on raw bit patterns; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [BITWIDTH-1:0] a,
                                 input logic [BITWIDTH-1:0] b);
    logic a_neg;
    logic b_neg;
    logic both_zero;
    a_neg     = a[BITWIDTH-1];
    b_neg     = b[BITWIDTH-1];
    both_zero = (a[BITWIDTH-2:0] == '0) && (b[BITWIDTH-2:0] == '0);
    if (a_neg != b_neg) begin
      fp_gt = both_zero ? 1'b0 : !a_neg;
    end else if (!a_neg) begin
      fp_gt = a[BITWIDTH-2:0] > b[BITWIDTH-2:0];
    end else begin
      fp_gt = a[BITWIDTH-2:0] < b[BITWIDTH-2:0];
    end
  endfunction

  // Optional ReLU: any value with the sign bit set (including -0) becomes +0.
  function automatic logic [BITWIDTH-1:0] relu(input logic [BITWIDTH-1:0] v);
    if ((RELUENABLE != 0) && v[BITWIDTH-1]) begin
      relu = '0;
    end else begin
      relu = v;
    end
  endfunction

  // Element / slot addressing from the window and position counters.
  always_comb begin
    elem_idx = ((32'(ch) * DATAHEIGHT + 32'(orow) * STRIDEHEIGHT + 32'(wr))
                * DATAWIDTH) + 32'(ocol) * STRIDEWIDTH + 32'(wc);
    out_idx  = (32'(ch) * OH + 32'(orow)) * OW + 32'(ocol);
    elem     = in_reg[BITWIDTH*elem_idx +: BITWIDTH];
    capture  = start && ((state == IDLE) || (state == DONE));
    first_elem = (wr == '0) && (wc == '0);
  end

  // Datapath: input capture and running-max accumulator (no reset needed).
  always_ff @(posedge clk) begin
    if (capture) begin
      in_reg <= data;
    end
    if (state == SCAN) begin
      if (first_elem || fp_gt(elem, acc)) begin
        acc <= elem;
      end
    end
  end

  // Control FSM: counters, result slots and the finish/busy handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      orow   <= '0;
      ocol   <= '0;
      wr     <= '0;
      wc     <= '0;
      result <= '0;
      finish <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch    <= '0;
            orow  <= '0;
            ocol  <= '0;
            wr    <= '0;
            wc    <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (wc == PW_LAST) begin
            wc <= '0;
            if (wr == PH_LAST) begin
              wr    <= '0;
              state <= WRITE;
            end else begin
              wr <= wr + 1'b1;
            end
          end else begin
            wc <= wc + 1'b1;
          end
        end

        WRITE: begin
          result[BITWIDTH*out_idx +: BITWIDTH] <= relu(acc);
          state <= SCAN;
          if (ocol == OW_LAST) begin
            ocol <= '0;
            if (orow == OH_LAST) begin
              orow <= '0;
              if (ch == C_LAST) begin
                ch     <= '0;
                state  <= DONE;
                finish <= 1'b1;
                busy   <= 1'b0;
              end else begin
                ch <= ch + 1'b1;
              end
            end else begin
              orow <= orow + 1'b1;
            end
          end else begin
            ocol <= ocol + 1'b1;
          end
        end

        DONE: begin
          if (start) begin
            ch     <= '0;
            orow   <= '0;
            ocol   <= '0;
            wr     <= '0;
            wc     <= '0;
            finish <= 1'b0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool2d_relu.sv
// Directed bench for max_pool2d_relu: default map with and without ReLU,
// signed zeros and ties, a 4x4 map, handshake robustness and mid-job reset.
module tb_max_pool2d_relu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, start_b, start_c;
  logic [255:0] data_a, data_b;
  logic [511:0] data_c;
  logic [63:0]  result_a, result_b;
  logic [127:0] result_c;
  logic         finish_a, finish_b, finish_c;
  logic         busy_a, busy_b, busy_c;

  int checks   = 0;
  int failures = 0;

  // ch1 = {BF800000, C0000000, BF000000, C0800000}, ch0 = {1.0, 3.0, -2.0, 5.5}
  localparam logic [255:0] VEC_A = {32'hC0800000, 32'hBF000000, 32'hC0000000, 32'hBF800000,
                                    32'h40B00000, 32'hC0000000, 32'h40400000, 32'h3F800000};
  // ch1 = {-3.0, 0.5, 0.5, -1.0}, ch0 = {-0, +0, -0, +0}
  localparam logic [255:0] VEC_T = {32'hBF800000, 32'h3F000000, 32'h3F000000, 32'hC0400000,
                                    32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000};

  logic [31:0] fp_tab [16];

  max_pool2d_relu #(.RELUENABLE(1)) u_def (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a),
    .result(result_a), .finish(finish_a), .busy(busy_a));

  max_pool2d_relu #(.RELUENABLE(0)) u_norelu (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .result(result_b), .finish(finish_b), .busy(busy_b));

  max_pool2d_relu #(.DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(1),
                    .RELUENABLE(1)) u_big (
    .clk(clk), .rst(rst), .start(start_c), .data(data_c),
    .result(result_c), .finish(finish_c), .busy(busy_c));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    fp_tab = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
               32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
               32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
    tick();
    tick();
    check("reset_result", result_a, 128'h0);
    check("reset_finish", finish_a, 128'h0);
    check("reset_busy", busy_a, 128'h0);
    rst = 1'b0;
    tick();
    check("idle_no_start_busy", busy_a, 128'h0);

    // Job A: both default instances, extra start in SCAN, data changed after capture
    data_a = VEC_A; data_b = VEC_A;
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    check("jobA_busy_rise", busy_a, 128'h1);
    check("jobA_finish_low_at_E", finish_a, 128'h0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin
        data_a = VEC_T; data_b = VEC_T;
      end
      if (k == 3) begin
        start_a = 1'b1; start_b = 1'b1;
      end
      tick();
      start_a = 1'b0; start_b = 1'b0;
      if (k < 10) begin
        check($sformatf("jobA_finish_low_k%0d", k), finish_a, 128'h0);
        check($sformatf("jobA_busy_high_k%0d", k), busy_a, 128'h1);
      end
    end
    check("jobA_finish_N10", finish_a, 128'h1);
    check("jobA_busy_fall", busy_a, 128'h0);
    check("jobA_result_relu", result_a, {64'h0, 32'h00000000, 32'h40B00000});
    check("jobA_result_norelu", result_b, {64'h0, 32'hBF000000, 32'h40B00000});
    check("jobA_finish_norelu", finish_b, 128'h1);
    tick();
    tick();
    check("jobA_done_hold_finish", finish_a, 128'h1);
    check("jobA_done_hold_result", result_a, {64'h0, 32'h00000000, 32'h40B00000});

    // Job T: restart from DONE with signed zeros / ties
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    check("jobT_finish_drop", finish_a, 128'h0);
    check("jobT_busy_rise", busy_a, 128'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        check("jobT_partial_relu", result_a, {64'h0, 32'h00000000, 32'h00000000});
        check("jobT_partial_norelu", result_b, {64'h0, 32'hBF000000, 32'h80000000});
      end
      if (k == 9) check("jobT_finish_low_k9", finish_a, 128'h0);
    end
    check("jobT_finish_N10", finish_a, 128'h1);
    check("jobT_result_relu", result_a, {64'h0, 32'h3F000000, 32'h00000000});
    check("jobT_result_norelu", result_b, {64'h0, 32'h3F000000, 32'h80000000});

    // Job C: 4x4 map, values 0.0..15.0
    for (int i = 0; i < 16; i++) data_c[32*i +: 32] = fp_tab[i];
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("jobC_busy_rise", busy_c, 128'h1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) check("jobC_finish_low_k19", finish_c, 128'h0);
    end
    check("jobC_finish_N20", finish_c, 128'h1);
    check("jobC_busy_fall", busy_c, 128'h0);
    check("jobC_result", result_c, {32'h41700000, 32'h41500000, 32'h40E00000, 32'h40A00000});

    // Job R: reset asserted during cycle 4 of a job
    data_a = VEC_A;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_result", result_a, 128'h0);
    check("rst_async_finish", finish_a, 128'h0);
    check("rst_async_busy", busy_a, 128'h0);
    check("rst_async_result_big", result_c, 128'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("rst_stay_result", result_a, 128'h0);
    check("rst_stay_busy", busy_a, 128'h0);
    check("rst_stay_finish", finish_a, 128'h0);

    data_a = VEC_A;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("jobR_busy_rise", busy_a, 128'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) check("jobR_finish_low_k9", finish_a, 128'h0);
    end
    check("jobR_finish_N10", finish_a, 128'h1);
    check("jobR_result", result_a, {64'h0, 32'h00000000, 32'h40B00000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_pool2d_relu.md
# max_pool2d_relu

Downstream stage of `Conv2d`. It captures the flattened FP32 feature map that the convolution produces and applies an optional ReLU. It then performs 2-D max pooling per channel, one comparison per clock, and delivers the pooled map on a flat bus with the same start/finish handshake as `Conv2d`. Its `data` input connects directly to `Conv2d.result`, and its `start` input is driven from `Conv2d.finish`.

## Interface
- BITWIDTH, 32: element width. IEEE-754 single precision is the only supported format.
- DATAWIDTH, 2: input map width (W).
- DATAHEIGHT, 2: input map height (H).
- DATACHANNEL, 2: channel count (C). This equals the upstream FILTERBATCH.
- POOLHEIGHT, 2: window height (PH).
- POOLWIDTH, 2: window width (PW).
- STRIDEHEIGHT, 2: vertical stride (SH).
- STRIDEWIDTH, 2: horizontal stride (SW).
- RELUENABLE, 1: 1 clamps negative pooled results to +0.
- Derived: OH = (H-PH)/SH+1, OW = (W-PW)/SW+1 (integer division).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. It is sampled on rising clk edges.
- data  in  BITWIDTH*W*H*C  input map. Element (c,r,x) sits at bits [BITWIDTH*((c*H+r)*W+x) +: BITWIDTH].
- result  out  BITWIDTH*OW*OH*C  pooled map. Element (c,r,x) sits at bits [BITWIDTH*((c*OH+r)*OW+x) +: BITWIDTH].
- finish  out  1  level signal, high while `result` is valid.
- busy  out  1  high from capture until finish rises.

## Operation
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - On `start`=1, copy `data` into an internal input register.
  - Clear the window and position counters (c, orow, ocol, wr, wc).
  - Set `busy`=1 and go to SCAN.
  - Once captured, upstream may change `data` freely.
- SCAN:
  - Each cycle, read element (c, orow*SH+wr, ocol*SW+wc).
  - The first element of each window (wr=wc=0) loads the accumulator unconditionally.
  - Every later element replaces the accumulator only if it is strictly greater. Ties keep the earlier element.
  - Window walk order is wc fastest, then wr. After PH*PW elements, go to WRITE.
- FP32 compare (a > b), with ±0 treated as equal:
  - Signs differ: the non-negative operand wins. If both are zero, the result is false.
  - Both non-negative: a > b iff a[30:0] > b[30:0].
  - Both negative: a > b iff a[30:0] < b[30:0].
  - NaN and denormal patterns are compared by these bit rules only. No special handling.
- WRITE:
  - Store the accumulator into the `result` slot (c, orow, ocol).
  - If RELUENABLE=1 and the accumulator sign bit is 1, store 32'h00000000 instead. This includes -0 → +0.
  - Advance ocol, then orow, then c. After the last window, go to DONE. Otherwise return to SCAN.
- DONE:
  - Hold `finish`=1, `busy`=0, and `result` stable.
  - On `start`=1, recapture `data` exactly as IDLE does, drop `finish`, and go to SCAN.
- `start` in SCAN or WRITE is ignored. A running job is never restarted.
- `result` slots not yet written in the current job keep their values from the previous job.

## Timing
- Reset values: `result`=0, `finish`=0, `busy`=0, state IDLE, all counters 0. Reset takes effect immediately and asynchronously.
- Reset asserted mid-job aborts the job. After release, the block waits in IDLE for a new `start`.
- Latency: let edge E be the one that samples `start`. `finish` is high after edge E+N, where N = C*OH*OW*(PH*PW+1).
  - For the default configuration, N = 2*1*1*5 = 10.
- Throughput: one element comparison per cycle, plus one write cycle per output.
- `busy` rises at edge E and falls on the same edge at which `finish` rises.
- `finish` falls at the edge that samples a new `start` in DONE.
- No combinational path exists from any input to any output. All outputs are registered.

## Test plan
- Default configuration, positive values:
  - Stimulus: channel 0 = {1.0 (3F800000), 3.0 (40400000), -2.0 (C0000000), 5.5 (40B00000)}.
  - Required: `result` channel 0 = 40B00000.
  - Required: `finish` high exactly 10 cycles after the `start` edge, and `busy` high in between.
- Default configuration, all-negative channel:
  - Stimulus: channel 1 = {BF800000, C0000000, BF000000, C0800000}.
  - Required: channel 1 = 00000000 with RELUENABLE=1, and BF000000 (-0.5) with RELUENABLE=0.
- Signed zeros and ties:
  - Stimulus: window {80000000, 00000000, 80000000, 00000000} with RELUENABLE=0.
  - Required: output = 80000000 (first element kept on ties).
  - Required: with RELUENABLE=1, output = 00000000.
- Larger map:
  - Stimulus: H=W=4, C=1, 2x2 window, stride 2, element value = (r*4+x) as FP32, i.e. 0.0..15.0.
  - Required: `result` = {5.0, 7.0, 13.0, 15.0} = {40A00000, 40E00000, 41500000, 41700000}.
  - Required: `finish` at N=20.
- Handshake robustness:
  - Stimulus: pulse `start` again during SCAN, and change `data` after capture.
  - Required: the job is unaffected, with the same result and the same N.
  - Stimulus: a new `start` in DONE.
  - Required: `finish` drops next edge, a second job runs, and its new results appear after N.
- Reset mid-job:
  - Stimulus: assert `rst` at cycle 4 of a job.
  - Required: `result`, `finish`, and `busy` go to 0 immediately and stay 0 until the next `start`.
  - Required: a subsequent job completes normally in N cycles.
